// File: rtl/store_write_buffer.sv
// Posted-write buffer between the MEM-stage store path and the data memory port.
// Stores queue in a circular FIFO and drain in order over a req/ack handshake.
// A store to the same word as the youngest non-head entry merges into that entry.
// Loads that hit a pending word raise ld_hit so the hazard unit can stall.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_be,
  output logic             st_ready,
  output logic             st_accept,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned WA_W  = 30;

  // Entry storage; validity is implied by rd_ptr/count, so no reset is needed.
  logic [WA_W-1:0]  waddr_q [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [3:0]       be_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             st_go;
  logic             do_merge;
  logic             do_alloc;
  logic             do_pop;
  logic [PTR_W-1:0] tail_idx;
  logic [31:0]      tail_data;
  logic [31:0]      merged_data;
  logic [PTR_W-1:0] offs;

  // Address byte-offset bits play no role in word matching.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // Status and head presentation, all derived from registered state.
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign st_ready  = (count_q < CNT_W'(DEPTH));
  assign mem_req   = !empty;
  assign mem_addr  = {waddr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = data_q[rd_ptr_q];
  assign mem_be    = be_q[rd_ptr_q];
  assign st_accept = do_merge | do_alloc;

  // Store decision: merge into tail (never the head), else allocate if room.
  always_comb begin
    st_go       = st_valid && (st_be != 4'b0000);
    tail_idx    = wr_ptr_q - PTR_W'(1);
    tail_data   = data_q[tail_idx];
    do_merge    = st_go && (count_q >= CNT_W'(2)) &&
                  (waddr_q[tail_idx] == st_addr[31:2]);
    do_alloc    = st_go && !do_merge && st_ready;
    do_pop      = mem_req && mem_ack;
    merged_data = {st_be[3] ? st_data[31:24] : tail_data[31:24],
                   st_be[2] ? st_data[23:16] : tail_data[23:16],
                   st_be[1] ? st_data[15:8]  : tail_data[15:8],
                   st_be[0] ? st_data[7:0]   : tail_data[7:0]};
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_alloc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
  end

  // Load hazard: compare against every live entry, including one being acked now.
  always_comb begin
    ld_hit = 1'b0;
    offs   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offs) < count_q) && (waddr_q[PTR_W'(i)] == ld_addr[31:2]))
        ld_hit = ld_valid;
    end
  end

  // Control state; reset empties the buffer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write: fresh allocation at wr_ptr or byte-wise merge into the tail.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      waddr_q[wr_ptr_q] <= st_addr[31:2];
      data_q[wr_ptr_q]  <= st_data;
      be_q[wr_ptr_q]    <= st_be;
    end else if (do_merge) begin
      data_q[tail_idx] <= merged_data;
      be_q[tail_idx]   <= be_q[tail_idx] | st_be;
    end
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write buffer between the pipeline's MEM-stage store path and the data memory port.
- Accepts byte-enabled stores in one cycle and queues them in a circular FIFO of DEPTH entries.
- Drains entries to memory in order over a req/ack handshake.
- Merges a store into the youngest queued entry when both target the same word.
- Flags loads that hit a pending word, so the hazard unit can stall the MEM stage.

Parameters:
DEPTH, 4, number of buffer entries (power of two, >=2)
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all buffer state
st_valid  in  1  MEM stage presents a store this cycle
st_addr  in  32  store byte address; bits [1:0] ignored
st_data  in  32  store data, lane-aligned
st_be  in  4  byte enables; bit i covers st_data[8i+7:8i]
st_ready  out  1  a new entry can be allocated (count<DEPTH)
st_accept  out  1  store taken this cycle, by allocation or merge
ld_valid  in  1  MEM stage presents a load this cycle
ld_addr  in  32  load byte address; bits [1:0] ignored
ld_hit  out  1  load word matches a pending entry; hazard unit must stall
mem_req  out  1  head entry presented to memory
mem_addr  out  32  head word address, {addr[31:2],2'b00}
mem_wdata  out  32  head data
mem_be  out  4  head byte enables
mem_ack  in  1  memory accepted the head this cycle
count  out  CNT_W  valid entries
empty  out  1  count==0

Behaviour:
- Storage: per entry, word address [31:2], data [31:0], be [3:0].
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH) bits, wrap modulo DEPTH; count is registered.
- Reset (async):
  - wr_ptr=rd_ptr=0, count=0.
  - Outputs: mem_req=0, empty=1, st_ready=1, st_accept=0, ld_hit=0.
  - Reset mid-transaction discards all entries; mem_req drops immediately, without waiting for a clock edge.
- Drain:
  - mem_req = !empty. mem_addr, mem_wdata and mem_be come straight from the head entry (combinational off registers).
  - Head fields stay stable while mem_req && !mem_ack.
  - mem_ack && mem_req pops the head at the clock edge; rd_ptr advances.
  - mem_ack while mem_req=0 is ignored.
  - Same-cycle ack is legal, so throughput is 1 entry/cycle.
- Store handling, evaluated every cycle:
  - st_valid=0 or st_be=0: nothing happens and st_accept=0.
  - Merge: applies when count>=2 and the tail entry (wr_ptr-1) word address equals st_addr[31:2].
    - Tail data is updated byte-wise where st_be=1.
    - tail be |= st_be.
    - count is unchanged.
    - st_accept=1, even when full.
  - Merge is never done into the head entry, because the head is on the bus. With count==1 and a matching address, a new entry is allocated instead.
  - Allocate: otherwise, if st_ready=1, write the entry at wr_ptr, advance wr_ptr, set st_accept=1.
  - If st_ready=0 and no merge: st_accept=0. The hazard unit stalls and the store is re-presented.
  - Full with a same-cycle pop: the store is still rejected, since st_ready derives from the registered count.
- Count update: +1 on allocate, -1 on pop. Allocate and pop in the same cycle leave count unchanged.
- Merge into the tail while the head pops in the same cycle is legal. With count==2 the merged tail becomes the new head next cycle.
- Load check (combinational):
  - ld_hit = ld_valid && (some valid entry has word address == ld_addr[31:2]).
  - An entry being acked this cycle still counts as pending.
  - ld_hit does not consider a store presented in the same cycle.
  - If st_valid and ld_valid are both 1 (illegal upstream), the store is processed normally and ld_hit still evaluates existing entries only.
- Ordering: memory observes stores in program order. A merged entry takes the position of the original tail.

Test Plan:
- Reset asserted while 3 entries are pending and mem_req=1 -> mem_req=0, count=0 and empty=1 immediately, before any clock edge.
- Push 4 stores (0x100, 0x104, 0x108, 0x10C; be=4'hF) with mem_ack=0 -> count=4, st_ready=0; a 5th store to 0x200 gives st_accept=0.
- Then hold mem_ack=1 -> mem_addr sequence is 0x100, 0x104, 0x108, 0x10C, one per cycle; empty=1 after the 4th ack.
- Merge case:
  - Queue 0x100 (be=F) and 0x204 (data 0x000000AA, be=4'b0001), with ack=0.
  - Then store 0x206 with data 0x00BB0000, be=4'b0100.
  - Required: count stays 2, st_accept=1, tail data 0x00BB00AA, be=4'b0101.
- Single-entry no-merge: count==1 at 0x300 and a store to 0x300 arrives -> count=2 with two separate entries, drained in order.
- Load hazard: entries at 0x400 and 0x404 pending; ld_addr=0x406 -> ld_hit=1; ld_addr=0x408 -> ld_hit=0; ld_hit clears the cycle after 0x404 is acked.
- Full with ack, then merge at full:
  - count=4, mem_ack=1 and a store to a new word -> rejected; count=3 next cycle.
  - Next cycle the same store -> accepted, count=4.
  - A store matching the tail at count=4 -> merged, st_accept=1.
